// File: rtl/mv_result_display.sv
// Shows a captured 6-bit product on one 7-segment digit as high hex digit, gap, low hex digit, gap, repeating.
// Optional macro MV_DISP_DP_EN lights the decimal point while the high digit is shown.
module mv_result_display #(
    parameter logic [23:0] MAX_COUNT   = 24'd10_000_000,
    parameter logic [23:0] BLANK_COUNT = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] result,
    input  logic       result_valid,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // result_valid is a one-cycle strobe with no back-pressure: the value present on
    // result at any edge where result_valid=1 is taken, and the display restarts from HI.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        GAP_H = 3'd2,
        LO    = 3'd3,
        GAP_L = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  val_q, val_d;
    logic [23:0] cnt_q, cnt_d;
    logic [6:0]  seg_q, seg_d;
    logic        busy_q, busy_d;

    function automatic logic [6:0] hex_font(input logic [3:0] d);
        logic [6:0] f;
        case (d)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        // A strobe outranks any dwell/blank expiry in the same cycle.
        if (result_valid) begin
            val_d   = result;
            state_d = HI;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                HI: begin
                    if (cnt_q == MAX_COUNT - 24'd1) begin
                        state_d = GAP_H;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                GAP_H: begin
                    if (cnt_q == BLANK_COUNT - 24'd1) begin
                        state_d = LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                LO: begin
                    if (cnt_q == MAX_COUNT - 24'd1) begin
                        state_d = GAP_L;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                GAP_L: begin
                    if (cnt_q == BLANK_COUNT - 24'd1) begin
                        state_d = HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        seg_d = 7'h00;
        case (state_d)
            HI:      seg_d = hex_font({2'b00, val_d[5:4]});
            LO:      seg_d = hex_font(val_d[3:0]);
            default: seg_d = 7'h00;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef MV_DISP_DP_EN
    logic dp_q, dp_d;
    assign dp_d = (state_d == HI);
    assign dp   = dp_q;
`else
    assign dp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= 7'h00;
            busy_q  <= 1'b0;
`ifdef MV_DISP_DP_EN
            dp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
`ifdef MV_DISP_DP_EN
            dp_q    <= dp_d;
`endif
        end
    end

    assign seg       = seg_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mv_result_display.sv
// Directed + randomized bench for mv_result_display, checked against a time-based model of the display cycle.
// Build with or without MV_DISP_DP_EN; the expected dp follows the same macro.
module tb_mv_result_display;

    localparam int M   = 4;
    localparam int B   = 2;
    localparam int PER = 2 * (M + B);

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] result;
    logic       result_valid;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a display is either inactive, or t cycles into the cycle started by the last strobe of mval.
    bit         active = 1'b0;
    logic [5:0] mval   = '0;
    int         t      = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] exp_q [$];

    mv_result_display #(
        .MAX_COUNT   (24'd4),
        .BLANK_COUNT (24'd2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .result_valid (result_valid),
        .seg          (seg),
        .dp           (dp),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg();
        int pos;
        if (!active) return 7'h00;
        pos = t % PER;
        if (pos < M)         return font[{2'b00, mval[5:4]}];
        if (pos < M + B)     return 7'h00;
        if (pos < 2 * M + B) return font[mval[3:0]];
        return 7'h00;
    endfunction

    function automatic logic exp_dp();
`ifdef MV_DISP_DP_EN
        return active && ((t % PER) < M);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag);
        logic [6:0] es;
        logic       ed;
        es = exp_seg();
        ed = exp_dp();
        n_checks++;
        assert (seg === es) else begin
            n_fail++;
            $error("FAIL %s seg observed=%h expected=%h (t=%0d)", tag, seg, es, t);
        end
        n_checks++;
        assert (dp === ed) else begin
            n_fail++;
            $error("FAIL %s dp observed=%b expected=%b (t=%0d)", tag, dp, ed, t);
        end
        n_checks++;
        assert (busy === active) else begin
            n_fail++;
            $error("FAIL %s busy observed=%b expected=%b (t=%0d)", tag, busy, active, t);
        end
    endtask

    // Present inputs before an edge, advance the model at that edge, check 1 time unit later.
    task automatic tick(input bit v, input logic [5:0] r, input string tag);
        result_valid = v;
        result       = r;
        @(posedge clk);
        if (v) begin
            active = 1'b1;
            mval   = r;
            t      = 0;
        end else if (active) begin
            t++;
        end
        #1;
        result_valid = 1'b0;
        check(tag);
    endtask

    initial begin
        rst          = 1'b1;
        result       = '0;
        result_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        rst = 1'b0;
        repeat (3) tick(1'b0, 6'h15, "idle_no_strobe");

        // 6'h2B: fixed expected sequence from the font table, two full periods.
        for (int p = 0; p < 2; p++) begin
            repeat (4) exp_q.push_back(7'h5B);
            repeat (2) exp_q.push_back(7'h00);
            repeat (4) exp_q.push_back(7'h7C);
            repeat (2) exp_q.push_back(7'h00);
        end
        tick(1'b1, 6'h2B, "seq_2b");
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            n_checks++;
            assert (seg === e) else begin
                n_fail++;
                $error("FAIL seq_2b_table seg observed=%h expected=%h", seg, e);
            end
            if (exp_q.size() > 0) tick(1'b0, 6'h2B, "seq_2b");
        end

        // Into LO (7C), then restart with 6'h05.
        repeat (7) tick(1'b0, 6'h2B, "to_lo");
        tick(1'b1, 6'h05, "restart_in_lo");
        n_checks++;
        assert (seg === 7'h3F) else begin
            n_fail++;
            $error("FAIL restart_in_lo_digit seg observed=%h expected=%h", seg, 7'h3F);
        end
        repeat (12) tick(1'b0, 6'h05, "after_restart");

        // Strobe on the last HI cycle: a full fresh HI, no gap.
        tick(1'b1, 6'h1A, "strobe_hi");
        repeat (3) tick(1'b0, 6'h1A, "hi_dwell");
        tick(1'b1, 6'h33, "strobe_last_hi");
        repeat (4) tick(1'b0, 6'h33, "hi_full_again");

        // Ignored result changes without the strobe.
        repeat (14) tick(1'b0, 6'($urandom_range(0, 63)), "no_strobe_change");

        // Back-to-back strobes: the last one wins.
        tick(1'b1, 6'h11, "b2b_0");
        tick(1'b1, 6'h22, "b2b_1");
        tick(1'b1, 6'h3C, "b2b_2");
        repeat (12) tick(1'b0, 6'h00, "b2b_show");

        // 6'h3F: 4F with dp (if enabled), gap, 71 without dp.
        tick(1'b1, 6'h3F, "val_3f");
        repeat (13) tick(1'b0, 6'h3F, "val_3f");

        // Reset mid-display, asserted away from any edge.
        tick(1'b1, 6'h27, "pre_reset");
        repeat (5) tick(1'b0, 6'h27, "pre_reset");
        #2;
        rst    = 1'b1;
        active = 1'b0;
        #1;
        check("async_reset");
        #1;
        rst = 1'b0;
        repeat (6) tick(1'b0, 6'h27, "idle_after_reset");

        // Randomized strobes and values.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
